// File: rtl/cpu_out_port.sv
`default_nettype none
// ============================================================================
// Module   : cpu_out_port
// Purpose  : Decodes the CPU's two-step OUT sequence (device address, then
//            data) and queues bytes addressed to this port in a small FIFO.
//            The FIFO drains to a sink over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_out_port #(
  parameter logic [7:0] DEV_ADDR   = 8'h01,
  parameter int         DEPTH_LOG2 = 2
) (
  input  logic                  in_clk,
  input  logic                  reset_n,
  input  logic [7:0]            cpu_interface,
  input  logic                  set_output,
  input  logic                  data_address,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  selected,
  output logic                  overflow
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Registered state
  logic                    strobe_q;
  logic                    selected_q,  selected_d;
  logic                    overflow_q,  overflow_d;
  logic [DEPTH_LOG2:0]     count_q,     count_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [7:0]              mem_q [DEPTH];

  // Decoded per-cycle controls
  logic strobe_evt;
  logic addr_evt;
  logic data_evt;
  logic push_req;
  logic push;
  logic pop;
  logic full;

  // Rising edge of the strobe level: a long-held strobe gives one event.
  always_comb begin
    strobe_evt = set_output & ~strobe_q;
    addr_evt   = strobe_evt &  data_address;
    data_evt   = strobe_evt & ~data_address;
    full       = (count_q == FULL_COUNT);
    pop        = out_valid & out_ready;
    push_req   = data_evt & selected_q;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push       = push_req & (~full | pop);
  end

  // Next-state for selection, overflow flag, pointers and occupancy.
  always_comb begin
    selected_d = selected_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (addr_evt) begin
      selected_d = (cpu_interface == DEV_ADDR);
    end

    if (push_req && !push) begin
      overflow_d = 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control registers with asynchronous clear.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q   <= 1'b0;
      selected_q <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      strobe_q   <= set_output;
      selected_q <= selected_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads 8'h00 when empty.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= cpu_interface;
    end
  end

  // Outputs come straight from registered state.
  always_comb begin
    out_data   = mem_q[rd_ptr_q];
    out_valid  = (count_q != '0);
    fifo_count = count_q;
    selected   = selected_q;
    overflow   = overflow_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_out_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_out_port
// Purpose  : Directed self-checking bench for cpu_out_port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_out_port;

  logic       in_clk;
  logic       reset_n;
  logic [7:0] cpu_interface;
  logic       set_output;
  logic       data_address;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_count;
  logic       selected;
  logic       overflow;

  int n_checks;
  int n_fails;

  cpu_out_port #(
    .DEV_ADDR   (8'h01),
    .DEPTH_LOG2 (2)
  ) dut (
    .in_clk        (in_clk),
    .reset_n       (reset_n),
    .cpu_interface (cpu_interface),
    .set_output    (set_output),
    .data_address  (data_address),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .fifo_count    (fifo_count),
    .selected      (selected),
    .overflow      (overflow)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  // One stepper step: strobe held for 'hold' cycles, then released for one.
  task automatic cpu_step(input logic is_addr, input logic [7:0] bus, input int hold);
    set_output    = 1'b1;
    data_address  = is_addr;
    cpu_interface = bus;
    repeat (hold) @(negedge in_clk);
    set_output    = 1'b0;
    data_address  = 1'b0;
    cpu_interface = 8'hxx;
    @(negedge in_clk);
  endtask

  // Check the head, then pop exactly one byte.
  task automatic drain_one(input logic [7:0] exp);
    check("drain_valid", 32'(out_valid), 32'h1);
    check("drain_data", 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    @(negedge in_clk);
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    reset_n       = 1'b0;
    cpu_interface = 8'h00;
    set_output    = 1'b0;
    data_address  = 1'b0;
    out_ready     = 1'b0;

    // Inputs toggling during reset must have no effect.
    for (int i = 0; i < 6; i++) begin
      set_output    = i[0];
      data_address  = ~i[1];
      cpu_interface = (i[0]) ? 8'h01 : 8'h5A;
      out_ready     = i[1];
      @(negedge in_clk);
    end
    check("rst_count",    32'(fifo_count), 32'h0);
    check("rst_valid",    32'(out_valid),  32'h0);
    check("rst_data",     32'(out_data),   32'h00);
    check("rst_selected", 32'(selected),   32'h0);
    check("rst_overflow", 32'(overflow),   32'h0);

    // Strobe already high at release counts as one address event.
    set_output    = 1'b1;
    data_address  = 1'b1;
    cpu_interface = 8'h01;
    out_ready     = 1'b0;
    reset_n       = 1'b1;
    @(negedge in_clk);
    check("release_evt_selected", 32'(selected), 32'h1);
    set_output    = 1'b0;
    cpu_interface = 8'hxx;
    idle(1);

    // Matched write: data strobe held 4 cycles yields one push.
    cpu_step(1'b1, 8'h01, 1);
    set_output    = 1'b1;
    data_address  = 1'b0;
    cpu_interface = 8'h5A;
    @(negedge in_clk);
    check("mw_count_n1", 32'(fifo_count), 32'h1);
    check("mw_valid_n1", 32'(out_valid),  32'h1);
    check("mw_data_n1",  32'(out_data),   32'h5A);
    idle(3);
    check("mw_count_held", 32'(fifo_count), 32'h1);
    set_output    = 1'b0;
    cpu_interface = 8'hxx;
    idle(1);

    // Unmatched address: following data byte is ignored.
    cpu_step(1'b1, 8'h02, 2);
    check("um_selected", 32'(selected), 32'h0);
    cpu_step(1'b0, 8'h33, 1);
    check("um_count", 32'(fifo_count), 32'h1);
    check("um_valid", 32'(out_valid),  32'h1);
    check("um_data",  32'(out_data),   32'h5A);
    drain_one(8'h5A);
    check("um_empty", 32'(out_valid), 32'h0);

    // Fill and overflow: selection persists across data events.
    cpu_step(1'b1, 8'h01, 1);
    for (int i = 0; i < 5; i++) begin
      cpu_step(1'b0, 8'h10 + 8'(i), 1);
      if (i == 3) check("fill_no_ovf_at_full", 32'(overflow), 32'h0);
    end
    check("fill_count",    32'(fifo_count), 32'h4);
    check("fill_overflow", 32'(overflow),   32'h1);
    for (int i = 0; i < 4; i++) drain_one(8'h10 + 8'(i));
    check("fill_empty_valid", 32'(out_valid),  32'h0);
    check("fill_empty_count", 32'(fifo_count), 32'h0);
    check("fill_ovf_sticky",  32'(overflow),   32'h1);

    // Reset pulse to clear the sticky flag.
    reset_n = 1'b0;
    @(negedge in_clk);
    reset_n = 1'b1;
    idle(1);
    check("pulse_ovf_clear", 32'(overflow), 32'h0);

    // Full with simultaneous pop.
    cpu_step(1'b1, 8'h01, 1);
    for (int i = 0; i < 4; i++) cpu_step(1'b0, 8'h10 + 8'(i), 1);
    check("fp_pre_count", 32'(fifo_count), 32'h4);
    set_output    = 1'b1;
    data_address  = 1'b0;
    cpu_interface = 8'hAA;
    out_ready     = 1'b1;
    @(negedge in_clk);
    out_ready     = 1'b0;
    set_output    = 1'b0;
    cpu_interface = 8'hxx;
    idle(1);
    check("fp_count",    32'(fifo_count), 32'h4);
    check("fp_overflow", 32'(overflow),   32'h0);
    drain_one(8'h11);
    drain_one(8'h12);
    drain_one(8'h13);
    drain_one(8'hAA);
    check("fp_empty", 32'(out_valid), 32'h0);

    // Reset mid-operation with 3 bytes queued and the port selected.
    for (int i = 0; i < 5; i++) cpu_step(1'b0, 8'h20 + 8'(i), 1);
    drain_one(8'h20);
    check("mid_pre_count",    32'(fifo_count), 32'h3);
    check("mid_pre_selected", 32'(selected),   32'h1);
    check("mid_pre_overflow", 32'(overflow),   32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_count",    32'(fifo_count), 32'h0);
    check("mid_selected", 32'(selected),   32'h0);
    check("mid_overflow", 32'(overflow),   32'h0);
    check("mid_valid",    32'(out_valid),  32'h0);
    check("mid_data",     32'(out_data),   32'h00);
    @(negedge in_clk);
    reset_n = 1'b1;
    idle(1);
    cpu_step(1'b0, 8'h77, 1);
    check("post_rst_count", 32'(fifo_count), 32'h0);
    check("post_rst_valid", 32'(out_valid),  32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
